// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage and F/D latch. It owns the PC, applies
//            stall/redirect and flags over-long stalls.
// Option   : FETCH_STALL_COUNTER_EN enables the stall_cycles perf counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int AW        = 12,
    parameter int MAX_STALL = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic [31:0]   imem_data,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   pc,
    output logic [31:0]   FD_IR,
    output logic [31:0]   FD_PC,
    output logic          dx_bubble,
    output logic [1:0]    fetch_state,
    output logic          stall_err,
    output logic [31:0]   stall_cycles
);

    localparam int             RW          = $clog2(MAX_STALL + 2);
    localparam logic [RW-1:0]  c_run_max   = RW'(MAX_STALL + 1);
    localparam logic [RW-1:0]  c_run_alarm = RW'(MAX_STALL);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_fd_ir;
    logic [31:0]   r_fd_pc;
    logic [RW-1:0] r_run;
    logic          r_stall_err;
    logic [31:0]   w_pc_plus1;
    logic          w_do_stall;

    assign w_pc_plus1 = r_pc + 32'd1;
    assign w_do_stall = stall & ~branch_taken;

    // Next-state selection: redirect beats stall beats normal flow.
    always_comb begin
        w_state_nxt = r_state;
        if (branch_taken) begin
            w_state_nxt = ST_FLUSH;
        end else if (stall) begin
            w_state_nxt = ST_STALL;
        end else begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= 32'd0;
            r_fd_ir     <= 32'd0;
            r_fd_pc     <= 32'd0;
            r_run       <= '0;
            r_stall_err <= 1'b0;
        end else if (branch_taken) begin
            // Squash the wrong-path word already sitting in imem_data.
            r_pc    <= branch_target;
            r_fd_ir <= 32'd0;
            r_fd_pc <= 32'd0;
            r_run   <= '0;
        end else if (stall) begin
            if (r_run != c_run_max) begin
                r_run <= r_run + 1'b1;
            end
            if (r_run == c_run_alarm) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_pc    <= w_pc_plus1;
            r_fd_ir <= imem_data;
            r_fd_pc <= w_pc_plus1;
            r_run   <= '0;
        end
    end

`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (w_do_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

    assign imem_addr   = r_pc[AW-1:0];
    assign pc          = r_pc;
    assign FD_IR       = r_fd_ir;
    assign FD_PC       = r_fd_pc;
    assign fetch_state = r_state;
    assign stall_err   = r_stall_err;
    assign dx_bubble   = w_do_stall & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed bench for fetch_stage with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam int AW        = 12;
    localparam int MAX_STALL = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [31:0]   branch_target = 32'd0;
    logic [31:0]   imem_data;
    logic [AW-1:0] imem_addr;
    logic [31:0]   pc, FD_IR, FD_PC, stall_cycles;
    logic          dx_bubble, stall_err;
    logic [1:0]    fetch_state;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    always #5 clock = ~clock;

    fetch_stage #(.AW(AW), .MAX_STALL(MAX_STALL)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_data(imem_data), .imem_addr(imem_addr), .pc(pc),
        .FD_IR(FD_IR), .FD_PC(FD_PC), .dx_bubble(dx_bubble),
        .fetch_state(fetch_state), .stall_err(stall_err),
        .stall_cycles(stall_cycles)
    );

    // Instruction ROM; address 3 deliberately holds a zero word.
    function automatic logic [31:0] rom(input logic [AW-1:0] a);
        if (a == 12'h000) return 32'h0840_0005;
        if (a == 12'h001) return 32'h0880_0007;
        if (a == 12'h003) return 32'h0000_0000;
        return {a, 8'h5A, a};
    endfunction

    assign imem_data = rom(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of the stage.
    logic [31:0] m_pc, m_ir, m_fdpc;
    int          m_state;
    int          m_consec;
    bit          m_err;
    longint      m_stalls;

    always @(posedge clock) begin
        if (reset) begin
            m_pc = 0; m_ir = 0; m_fdpc = 0; m_state = 0;
            m_consec = 0; m_err = 0; m_stalls = 0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_ir = 0; m_fdpc = 0; m_state = 2;
            m_consec = 0;
        end else if (stall) begin
            m_state = 1;
            m_consec++;
            if (m_consec > MAX_STALL) m_err = 1;
            if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
        end else begin
            m_ir   = rom(m_pc[AW-1:0]);
            m_fdpc = m_pc + 32'd1;
            m_pc   = m_pc + 32'd1;
            m_state = 0;
            m_consec = 0;
        end
    end

    function automatic logic [31:0] exp_cycles();
`ifdef FETCH_STALL_COUNTER_EN
        return m_stalls[31:0];
`else
        return 32'd0;
`endif
    endfunction

    // Every-cycle compare against the model, mid-cycle.
    always @(negedge clock) begin
        if (armed) begin
            chk("m_pc", pc, m_pc);
            chk("m_fd_ir", FD_IR, m_ir);
            chk("m_fd_pc", FD_PC, m_fdpc);
            chk("m_state", {30'd0, fetch_state}, m_state[31:0]);
            chk("m_stall_err", {31'd0, stall_err}, {31'd0, m_err});
            chk("m_stall_cycles", stall_cycles, exp_cycles());
            chk("m_imem_addr", {20'd0, imem_addr}, {20'd0, m_pc[AW-1:0]});
            chk("m_dx_bubble", {31'd0, dx_bubble},
                {31'd0, stall & ~branch_taken & ~reset});
        end
    end

    task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic r);
        stall = s; branch_taken = b; branch_target = t; reset = r;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        // Reset
        drive(0, 0, 0, 1);
        tick(); tick();
        armed = 1'b1;
        chk("rst_pc", pc, 32'd0);
        chk("rst_fd_ir", FD_IR, 32'd0);
        chk("rst_fd_pc", FD_PC, 32'd0);
        chk("rst_state", {30'd0, fetch_state}, 32'd0);
        chk("rst_err", {31'd0, stall_err}, 32'd0);
        chk("rst_cycles", stall_cycles, 32'd0);

        // Straight-line fetch
        drive(0, 0, 0, 0);
        tick();
        chk("run1_ir", FD_IR, 32'h0840_0005);
        chk("run1_fdpc", FD_PC, 32'd1);
        chk("run1_pc", pc, 32'd1);
        tick();
        chk("run2_ir", FD_IR, 32'h0880_0007);
        chk("run2_fdpc", FD_PC, 32'd2);
        chk("run2_pc", pc, 32'd2);
        tick(); tick();
        chk("zero_word_ir", FD_IR, 32'd0);
        chk("zero_word_fdpc", FD_PC, 32'd4);
        tick();
        chk("run5_pc", pc, 32'd5);
        chk("run5_ir", FD_IR, 32'h0045_A004);

        // Two-cycle stall at pc=5
        drive(1, 0, 0, 0);
        #1 chk("stall_bubble0", {31'd0, dx_bubble}, 32'd1);
        tick();
        chk("stall1_pc", pc, 32'd5);
        chk("stall1_ir", FD_IR, 32'h0045_A004);
        chk("stall1_state", {30'd0, fetch_state}, 32'd1);
        chk("stall_bubble1", {31'd0, dx_bubble}, 32'd1);
        tick();
        chk("stall2_pc", pc, 32'd5);
        drive(0, 0, 0, 0);
        tick();
        chk("unstall_pc", pc, 32'd6);
        chk("unstall_state", {30'd0, fetch_state}, 32'd0);
`ifdef FETCH_STALL_COUNTER_EN
        chk("unstall_cycles", stall_cycles, 32'd2);
`else
        chk("unstall_cycles", stall_cycles, 32'd0);
`endif

        // Stall and branch together: branch wins
        drive(1, 1, 32'h40, 0);
        #1 chk("brstall_bubble", {31'd0, dx_bubble}, 32'd0);
        tick();
        chk("br_pc", pc, 32'h40);
        chk("br_ir", FD_IR, 32'd0);
        chk("br_fdpc", FD_PC, 32'd0);
        chk("br_state", {30'd0, fetch_state}, 32'd2);
        drive(0, 0, 0, 0);
        tick();
        chk("tgt_ir", FD_IR, 32'h0405_A040);
        chk("tgt_fdpc", FD_PC, 32'h41);
        chk("tgt_state", {30'd0, fetch_state}, 32'd0);

        // Back-to-back branches keep FLUSH
        drive(0, 1, 32'h10, 0);
        tick();
        drive(0, 1, 32'h20, 0);
        tick();
        chk("b2b_state", {30'd0, fetch_state}, 32'd2);
        chk("b2b_pc", pc, 32'h20);
        drive(0, 0, 0, 0);
        tick();
        chk("b2b_ir", FD_IR, 32'h0205_A020);

        // Long stall raises sticky stall_err
        drive(0, 0, 0, 1);
        tick();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("err_after4", {31'd0, stall_err}, 32'd0);
        tick();
        chk("err_after5", {31'd0, stall_err}, 32'd1);
        drive(0, 0, 0, 0);
        tick(); tick();
        chk("err_sticky", {31'd0, stall_err}, 32'd1);
        drive(0, 0, 0, 1);
        tick();
        chk("err_cleared", {31'd0, stall_err}, 32'd0);

        // PC wrap
        drive(0, 1, 32'hFFFF_FFFF, 0);
        tick();
        chk("wrap_addr", {20'd0, imem_addr}, 32'h0000_0FFF);
        drive(0, 0, 0, 0);
        tick();
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_fdpc", FD_PC, 32'd0);
        chk("wrap_ir", FD_IR, 32'hFFF5_AFFF);

        // Reset mid-stall
        drive(0, 1, 32'd9, 0);
        tick();
        drive(1, 0, 0, 0);
        tick();
        chk("ms_state", {30'd0, fetch_state}, 32'd1);
        chk("ms_pc", pc, 32'd9);
        drive(1, 0, 0, 1);
        #1 chk("ms_bubble_rst", {31'd0, dx_bubble}, 32'd0);
        tick();
        chk("msr_pc", pc, 32'd0);
        chk("msr_ir", FD_IR, 32'd0);
        chk("msr_state", {30'd0, fetch_state}, 32'd0);
        chk("msr_err", {31'd0, stall_err}, 32'd0);
        chk("msr_cycles", stall_cycles, 32'd0);

        // Reset together with a branch: reset wins
        drive(0, 1, 32'h77, 1);
        tick();
        chk("rstbr_pc", pc, 32'd0);
        chk("rstbr_state", {30'd0, fetch_state}, 32'd0);
        drive(0, 0, 0, 0);
        tick(); tick();

        @(negedge clock);
        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
